// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
// Turns the HPS byte download stream into per-region ROM write strobes for
// the phoenix core, keeps the core in reset while an image is loading and for
// a settle period afterwards, and reports load status, byte count and a
// running checksum of the accepted bytes.

module rom_load_sequencer #(
    parameter logic [15:0] PROG_BASE   = 16'h0000,
    parameter logic [15:0] BG_BASE     = 16'h4000,
    parameter logic [15:0] FG_BASE     = 16'h5000,
    parameter logic [15:0] PROM_BASE   = 16'h6000,
    parameter logic [15:0] ROM_END     = 16'h61FF,
    parameter int          HOLD_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        wr_prog,
    output logic        wr_bg,
    output logic        wr_fg,
    output logic        wr_prom,
    output logic        core_reset,
    output logic        rom_ready,
    output logic        load_error,
    output logic [7:0]  checksum,
    output logic [16:0] byte_count
);

    // Width of the settle counter; a single settle cycle still needs one bit.
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    // A complete image covers every address from zero up to ROM_END.
    localparam logic [16:0] FULL_COUNT = {1'b0, ROM_END} + 17'd1;
    localparam logic [16:0] COUNT_MAX  = 17'h1FFFF;

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        HOLD,
        RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic              download_d;
    logic              dl_rise;
    logic              dl_fall;

    logic [15:0]       addr_lo;
    logic              below_prog;
    logic              in_range;
    logic              wr_in_load;
    logic              write_ok;
    logic              sel_prog;
    logic              sel_bg;
    logic              sel_fg;
    logic              sel_prom;

    logic [16:0]       byte_count_inc;
    logic [16:0]       byte_count_next;
    logic [7:0]        checksum_next;
    logic              oor_seen;
    logic              oor_seen_next;

    logic [HOLD_W-1:0] hold_cnt;
    logic              start_hold;
    logic              set_error;

    // Only the lower 16 address bits address the ROM image; anything with
    // upper bits set, or past ROM_END, belongs to no region.
    assign addr_lo = ioctl_addr[15:0];

    generate
        if (PROG_BASE == 16'h0000) begin : g_prog_at_zero
            assign below_prog = 1'b0;
        end else begin : g_prog_offset
            assign below_prog = (addr_lo < PROG_BASE);
        end
    endgenerate

    assign in_range   = (ioctl_addr[24:16] == 9'd0) && !below_prog && (addr_lo <= ROM_END);
    assign wr_in_load = (state == LOAD) && ioctl_wr;
    assign write_ok   = wr_in_load && in_range;

    assign sel_prog = (addr_lo < BG_BASE);
    assign sel_bg   = (addr_lo >= BG_BASE) && (addr_lo < FG_BASE);
    assign sel_fg   = (addr_lo >= FG_BASE) && (addr_lo < PROM_BASE);
    assign sel_prom = (addr_lo >= PROM_BASE);

    // The download edges come from a one-cycle-delayed copy so a byte written
    // in the same cycle as the falling edge is still inside the load.
    assign dl_rise = ioctl_download && !download_d;
    assign dl_fall = !ioctl_download && download_d;

    // Counter and checksum values including this cycle's byte, so the
    // end-of-load check sees a byte that arrives together with the falling edge.
    assign byte_count_inc  = (byte_count == COUNT_MAX) ? byte_count : byte_count + 17'd1;
    assign byte_count_next = write_ok ? byte_count_inc : byte_count;
    assign checksum_next   = write_ok ? checksum + ioctl_dout : checksum;
    assign oor_seen_next   = oor_seen || (wr_in_load && !in_range);

    // Delayed copy of the download flag; it follows the input even during
    // reset so a download still high when reset lifts is not seen as a new one.
    always_ff @(posedge clk) begin
        download_d <= ioctl_download;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a new download restarts loading from any state; the end
    // of a load either starts the settle period or rejects the image.
    always_comb begin
        state_next = state;
        start_hold = 1'b0;
        set_error  = 1'b0;
        if (dl_rise) begin
            state_next = LOAD;
        end else begin
            case (state)
                EMPTY: begin
                    state_next = EMPTY;
                end
                LOAD: begin
                    if (dl_fall) begin
                        if ((byte_count_next != FULL_COUNT) || oor_seen_next) begin
                            set_error  = 1'b1;
                            state_next = EMPTY;
                        end else begin
                            start_hold = 1'b1;
                            state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    state_next = RUN;
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    // Output decode: the core only runs once a verified image has settled.
    always_comb begin
        core_reset = (state != RUN);
        rom_ready  = (state == RUN);
    end

    // Settle counter: loaded when a good image finishes, counts down in HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (start_hold) begin
            hold_cnt <= HOLD_LOAD;
        end else if ((state == HOLD) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Write path: register the byte and raise exactly one region strobe for a
    // single cycle; the address and data lines keep their last accepted value.
    always_ff @(posedge clk) begin
        if (reset) begin
            dn_addr <= '0;
            dn_data <= '0;
            wr_prog <= 1'b0;
            wr_bg   <= 1'b0;
            wr_fg   <= 1'b0;
            wr_prom <= 1'b0;
        end else begin
            wr_prog <= write_ok && sel_prog;
            wr_bg   <= write_ok && sel_bg;
            wr_fg   <= write_ok && sel_fg;
            wr_prom <= write_ok && sel_prom;
            if (write_ok) begin
                dn_addr <= addr_lo;
                dn_data <= ioctl_dout;
            end
        end
    end

    // Load statistics: cleared when a download starts, accumulated per accepted
    // byte, with a sticky flag for bytes that fell outside the image.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_count <= '0;
            checksum   <= '0;
            oor_seen   <= 1'b0;
            load_error <= 1'b0;
        end else if (dl_rise) begin
            byte_count <= '0;
            checksum   <= '0;
            oor_seen   <= 1'b0;
            load_error <= 1'b0;
        end else begin
            byte_count <= byte_count_next;
            checksum   <= checksum_next;
            oor_seen   <= oor_seen_next;
            if (set_error) begin
                load_error <= 1'b1;
            end
        end
    end

endmodule

// File: doc/rom_load_sequencer.md
Name: rom_load_sequencer

Overview:
- Sits between the HPS download stream and the phoenix core in the Pleiads top level.
- Decodes each downloaded byte into a ROM region write strobe: program, background chars, foreground chars, or colour PROM.
- Holds the core in reset during the download and for a fixed settle period afterwards.
- Reports completion, byte count, running checksum and short-load errors. Replaces the direct ioctl wiring to the core.

Parameters:
- PROG_BASE, 16'h0000, first address of program ROM region
- BG_BASE, 16'h4000, first address of background character region
- FG_BASE, 16'h5000, first address of foreground character region
- PROM_BASE, 16'h6000, first address of colour PROM region
- ROM_END, 16'h61FF, last valid address; bytes above it are dropped
- HOLD_CYCLES, 256, clk cycles core_reset stays high after download ends (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- ioctl_download  in  1  download in progress
- ioctl_wr  in  1  one-cycle byte-valid strobe
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- dn_addr  out  16  registered address to ROM regions
- dn_data  out  8  registered data to ROM regions
- wr_prog  out  1  program ROM write enable
- wr_bg  out  1  background ROM write enable
- wr_fg  out  1  foreground ROM write enable
- wr_prom  out  1  PROM write enable
- core_reset  out  1  reset request to core (ORed with user reset at top)
- rom_ready  out  1  valid image loaded, core running
- load_error  out  1  last download was short or out of range
- checksum  out  8  mod-256 sum of accepted bytes of last/current load
- byte_count  out  17  accepted byte count of last/current load

Behaviour:
- Reset values:
  - All outputs 0, except core_reset=1.
  - State EMPTY.
- States:
  - EMPTY: no image loaded. core_reset=1, rom_ready=0.
  - LOAD: entered on ioctl_download rising edge, from any state. Clears checksum, byte_count and load_error on entry. core_reset=1.
  - HOLD: entered on ioctl_download falling edge.
    - If byte_count ≠ ROM_END+1, or any byte had addr > ROM_END: load_error=1 and go to EMPTY.
    - Otherwise load the hold counter with HOLD_CYCLES-1 and decrement each cycle.
  - RUN: entered when the HOLD counter reaches 0. core_reset=0, rom_ready=1.
- Write path (LOAD state only):
  - On an ioctl_wr cycle, register dn_addr=ioctl_addr[15:0] and dn_data=ioctl_dout.
  - Assert exactly one wr_* for one cycle, next cycle (latency 1).
  - Region select, by address a:
    - PROG_BASE ≤ a < BG_BASE → wr_prog
    - BG_BASE ≤ a < FG_BASE → wr_bg
    - FG_BASE ≤ a < PROM_BASE → wr_fg
    - PROM_BASE ≤ a ≤ ROM_END → wr_prom
  - If ioctl_addr[24:16] ≠ 0 or a > ROM_END:
    - No strobe is asserted.
    - The byte is not counted and not summed.
    - The sticky out-of-range flag is set and reported in HOLD.
- Counting:
  - Each accepted byte increments byte_count; it saturates at 17'h1FFFF.
  - checksum += data, mod 256, updated the same cycle as the strobe.
- Ignored inputs:
  - ioctl_wr outside LOAD is ignored.
  - ioctl_wr on the same cycle as the ioctl_download falling edge is still accepted; the edge is detected from a one-cycle-delayed copy.
- Boundary cases:
  - A new download during HOLD or RUN restarts LOAD immediately. core_reset rises the next cycle.
  - Synchronous reset mid-LOAD aborts the load: state goes to EMPTY and all strobes drop the next cycle.
  - Back-to-back ioctl_wr on consecutive cycles must each produce a strobe. No buffering is needed; throughput is 1 byte/cycle.
- dn_addr and dn_data hold their last value when no strobe is active.

Test Plan:
- Reset, then no download → core_reset=1, rom_ready=0, all wr_*=0 indefinitely.
- Full load of 0x6200 bytes, data=addr[7:0]:
  - Strobe counts: wr_prog 0x4000, wr_bg 0x1000, wr_fg 0x1000, wr_prom 0x200.
  - byte_count=0x6200, checksum=8'h00.
  - After the download falls: core_reset stays 1 for exactly 256 cycles, then core_reset=0 and rom_ready=1.
- Boundary addresses 0x3FFF/0x4000, 0x4FFF/0x5000, 0x5FFF/0x6000 → strobe switches region exactly at each base; dn_addr and dn_data match the inputs delayed by one cycle.
- Short load (0x6000 bytes) → load_error=1, state EMPTY, core_reset held at 1, rom_ready=0.
- Byte at addr 0x6200 or 0x10000 inside an otherwise full load → no strobe for that byte, byte_count unaffected, load_error=1 after the download ends.
- Reload while in RUN → core_reset=1 the next cycle and checksum/byte_count cleared. Synchronous reset asserted mid-load → EMPTY, and the next full load succeeds normally.
